scene_animator: RTL and testbench

- Per-frame scene parameter generator in the clk_render domain, upstream of triangle_feeder and render_manager.
- On each begin_frame pulse it advances the screen-space offsets (offset_x, offset_y) and the object's Y-axis rotation.
- Rotation is advanced by an incremental sin/cos recurrence on one shared multiplier, and the result is presented as a complete transform_t.
- Replaces the free-running offset logic and constant transform currently tied off at top level.

---
 rtl/scene_animator.sv | 147 ++++++++++++++
 tb/tb_scene_animator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_animator.sv
// rtl/scene_animator.sv - per-frame scene offsets and Y-axis rotation generator
// Sin/cos advance by a stable incremental recurrence that shares one multiplier.
module scene_animator #(
   parameter int unsigned FB_WIDTH      = 160,
   parameter int unsigned FB_HEIGHT     = 120,
   parameter logic [31:0] OFFSET_X_STEP = 32'h0000_8000,
   parameter logic [31:0] OFFSET_Y_STEP = 32'h0000_2000,
   parameter logic [31:0] ROT_EPS       = 32'h0000_0324,
   parameter int unsigned STEPS_PER_REV = 512
) (
   input  logic         clk_render,
   input  logic         btn_rst_n,
   input  logic         begin_frame,
   input  logic         pause,
   output logic [31:0]  offset_x,
   output logic [31:0]  offset_y,
   output logic [383:0] transform,
   output logic         update_done,
   output logic         busy,
   output logic [15:0]  frame_count,
   output logic [15:0]  dropped_frames
);

   localparam int unsigned      REV_W    = $clog2(STEPS_PER_REV);
   localparam logic [REV_W-1:0] REV_LAST = REV_W'(STEPS_PER_REV - 1);
   localparam logic [31:0]      X_LIM    = 32'(FB_WIDTH) << 15;
   localparam logic [31:0]      X_START  = ~X_LIM + 32'd1;
   localparam logic [31:0]      Y_LIM    = 32'(FB_HEIGHT) << 15;
   localparam logic [31:0]      ONE      = 32'h0001_0000;
   localparam logic [31:0]      POS_Z    = 32'hFFF6_0000;
   localparam logic [31:0]      SIN_X    = 32'h0000_8000;
   localparam logic [31:0]      COS_X    = 32'h0000_DDB4;
   localparam logic [31:0]      SCALE    = 32'h0000_199A;

   typedef enum logic [1:0] {IDLE, MUL_S, MUL_C, COMMIT} state_t;

   state_t           state_q, state_d;
   logic [31:0]      s_q, s_d, c_q, c_d;
   logic [31:0]      sin_y_q, sin_y_d, cos_y_q, cos_y_d;
   logic [31:0]      off_x_q, off_x_d, off_y_q, off_y_d;
   logic [REV_W-1:0] rev_q, rev_d;
   logic [15:0]      frame_q, frame_d, drop_q, drop_d;
   logic             done_q, done_d;

   logic [31:0]      mul_b;
   logic [63:0]      prod;
   logic [31:0]      prod_term;
   logic             unused_prod_bits;

   // One multiplier: eps*c while forming s_n, then eps*s_n while forming c_n.
   assign mul_b            = (state_q == MUL_S) ? c_q : s_q;
   assign prod             = {{32{ROT_EPS[31]}}, ROT_EPS} * {{32{mul_b[31]}}, mul_b};
   assign prod_term        = prod[47:16];
   assign unused_prod_bits = ^{prod[63:48], prod[15:0]};

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      c_d     = c_q;
      sin_y_d = sin_y_q;
      cos_y_d = cos_y_q;
      off_x_d = off_x_q;
      off_y_d = off_y_q;
      rev_d   = rev_q;
      frame_d = frame_q;
      drop_d  = drop_q;
      done_d  = 1'b0;

      if (begin_frame && (state_q != IDLE) && (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (begin_frame && !pause) begin
               state_d = MUL_S;
               s_d     = sin_y_q;
               c_d     = cos_y_q;
            end
         end
         MUL_S: begin
            s_d     = s_q + prod_term;
            state_d = MUL_C;
         end
         MUL_C: begin
            c_d     = c_q - prod_term;
            state_d = COMMIT;
         end
         COMMIT: begin
            if (rev_q == REV_LAST) begin
               sin_y_d = 32'd0;
               cos_y_d = ONE;
               rev_d   = '0;
            end else begin
               sin_y_d = s_q;
               cos_y_d = c_q;
               rev_d   = rev_q + 1'b1;
            end
            off_x_d = ($signed(off_x_q) >= $signed(X_LIM)) ? X_START : off_x_q + OFFSET_X_STEP;
            off_y_d = ($signed(off_y_q) >= $signed(Y_LIM)) ? 32'd0 : off_y_q + OFFSET_Y_STEP;
            frame_d = frame_q + 16'd1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_render or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         state_q <= IDLE;
         s_q     <= 32'd0;
         c_q     <= 32'd0;
         sin_y_q <= 32'd0;
         cos_y_q <= ONE;
         off_x_q <= X_START;
         off_y_q <= 32'd0;
         rev_q   <= '0;
         frame_q <= 16'd0;
         drop_q  <= 16'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         sin_y_q <= sin_y_d;
         cos_y_q <= cos_y_d;
         off_x_q <= off_x_d;
         off_y_q <= off_y_d;
         rev_q   <= rev_d;
         frame_q <= frame_d;
         drop_q  <= drop_d;
         done_q  <= done_d;
      end
   end

   assign offset_x       = off_x_q;
   assign offset_y       = off_y_q;
   assign update_done    = done_q;
   assign busy           = (state_q != IDLE);
   assign frame_count    = frame_q;
   assign dropped_frames = drop_q;
   assign transform      = {32'd0, 32'd0, POS_Z,
                            SIN_X, sin_y_q, 32'd0,
                            COS_X, cos_y_q, ONE,
                            SCALE, SCALE, SCALE};

endmodule

// File: tb/tb_scene_animator.sv
// tb/tb_scene_animator.sv - randomized self-checking bench for scene_animator
// Expected values come from an arithmetic model of the per-frame update rules.
module tb_scene_animator;

   localparam longint EPS   = 804;
   localparam longint X_LIM = 160 * 32768;
   localparam longint Y_LIM = 120 * 32768;
   localparam logic [319:0] FIXED_EXP = {32'h0, 32'h0, 32'hFFF6_0000, 32'h0000_8000,
                                         32'h0, 32'h0000_DDB4,
                                         32'h0001_0000, 32'h0000_199A, 32'h0000_199A, 32'h0000_199A};

   logic         clk_render = 1'b0;
   logic         btn_rst_n;
   logic         begin_frame;
   logic         pause;
   logic [31:0]  offset_x;
   logic [31:0]  offset_y;
   logic [383:0] transform;
   logic         update_done;
   logic         busy;
   logic [15:0]  frame_count;
   logic [15:0]  dropped_frames;

   logic [31:0]  sin_y, cos_y;
   logic [319:0] fixed_f;

   int checks = 0;
   int failures = 0;

   longint m_sin, m_cos, m_offx, m_offy;
   int     m_frames, m_drops, m_updates;

   scene_animator dut (
      .clk_render     (clk_render),
      .btn_rst_n      (btn_rst_n),
      .begin_frame    (begin_frame),
      .pause          (pause),
      .offset_x       (offset_x),
      .offset_y       (offset_y),
      .transform      (transform),
      .update_done    (update_done),
      .busy           (busy),
      .frame_count    (frame_count),
      .dropped_frames (dropped_frames)
   );

   always #5 clk_render = ~clk_render;

   assign sin_y   = transform[255:224];
   assign cos_y   = transform[159:128];
   assign fixed_f = {transform[383:256], transform[223:160], transform[127:0]};

   function automatic void model_reset();
      m_sin = 0; m_cos = 65536; m_offx = -X_LIM; m_offy = 0;
      m_frames = 0; m_drops = 0; m_updates = 0;
   endfunction

   function automatic void model_step();
      longint sn, cn;
      m_updates++;
      if (m_updates % 512 == 0) begin
         m_sin = 0; m_cos = 65536;
      end else begin
         sn = m_sin + ((EPS * m_cos) >>> 16);
         cn = m_cos - ((EPS * sn) >>> 16);
         m_sin = sn; m_cos = cn;
      end
      if (m_offx >= X_LIM) m_offx = -X_LIM; else m_offx = m_offx + 32768;
      if (m_offy >= Y_LIM) m_offy = 0;      else m_offy = m_offy + 8192;
      m_frames = (m_frames + 1) % 65536;
   endfunction

   task automatic apply_reset();
      btn_rst_n = 1'b0; begin_frame = 1'b0; pause = 1'b0;
      repeat (3) @(posedge clk_render);
      #1 btn_rst_n = 1'b1;
      model_reset();
   endtask

   task automatic frame(input logic p, output logic got);
      @(posedge clk_render); #1; pause = p; begin_frame = 1'b1;
      @(posedge clk_render); #1; begin_frame = 1'b0; pause = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk_render); #1;
         if (update_done) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (offset_x !== 32'hFFB0_0000) begin failures++; $display("FAIL reset_offset_x got=%h exp=FFB00000", offset_x); end
      checks++; if (offset_y !== 32'h0) begin failures++; $display("FAIL reset_offset_y got=%h exp=0", offset_y); end
      checks++; if (sin_y !== 32'h0) begin failures++; $display("FAIL reset_sin_y got=%h exp=0", sin_y); end
      checks++; if (cos_y !== 32'h0001_0000) begin failures++; $display("FAIL reset_cos_y got=%h exp=00010000", cos_y); end
      checks++; if (busy !== 1'b0 || update_done !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, update_done); end
      checks++; if (frame_count !== 16'd0 || dropped_frames !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", frame_count, dropped_frames); end
      checks++; if (fixed_f !== FIXED_EXP) begin failures++; $display("FAIL reset_fixed got=%h exp=%h", fixed_f, FIXED_EXP); end
   endtask

   task automatic test_single();
      apply_reset();
      @(posedge clk_render); #1; begin_frame = 1'b1;
      @(posedge clk_render); #1; begin_frame = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (busy !== 1'b1 || update_done !== 1'b0) begin failures++; $display("FAIL single_busy_%0d got busy=%b done=%b exp 1 0", k, busy, update_done); end
         checks++; if (offset_x !== 32'hFFB0_0000 || sin_y !== 32'h0) begin failures++; $display("FAIL single_hold_%0d got x=%h s=%h exp FFB00000 0", k, offset_x, sin_y); end
         @(posedge clk_render); #1;
      end
      checks++; if (update_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_done got done=%b busy=%b exp 1 0", update_done, busy); end
      checks++; if (sin_y !== 32'h0000_0324) begin failures++; $display("FAIL single_sin got=%h exp=00000324", sin_y); end
      checks++; if (cos_y !== 32'h0000_FFF7) begin failures++; $display("FAIL single_cos got=%h exp=0000FFF7", cos_y); end
      checks++; if (offset_x !== 32'hFFB0_8000) begin failures++; $display("FAIL single_offset_x got=%h exp=FFB08000", offset_x); end
      checks++; if (offset_y !== 32'h0000_2000) begin failures++; $display("FAIL single_offset_y got=%h exp=00002000", offset_y); end
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL single_frames got=%0d exp=1", frame_count); end
      checks++; if (fixed_f !== FIXED_EXP) begin failures++; $display("FAIL single_fixed got=%h exp=%h", fixed_f, FIXED_EXP); end
      @(posedge clk_render); #1;
      checks++; if (update_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", update_done); end
   endtask

   task automatic test_back_to_back();
      logic got;
      apply_reset();
      @(posedge clk_render); #1; begin_frame = 1'b1;
      @(posedge clk_render); #1;
      @(posedge clk_render); #1; begin_frame = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk_render); #1;
         if (update_done) got = 1'b1;
      end
      checks++; if (!got) begin failures++; $display("FAIL b2b_timeout got=no update exp=update"); end
      checks++; if (dropped_frames !== 16'd1 || frame_count !== 16'd1) begin failures++; $display("FAIL b2b_first got drop=%0d frames=%0d exp 1 1", dropped_frames, frame_count); end
      @(posedge clk_render); #1; begin_frame = 1'b1;
      @(posedge clk_render); #1; begin_frame = 1'b0;
      @(posedge clk_render); #1;
      @(posedge clk_render); #1; begin_frame = 1'b1;
      @(posedge clk_render); #1; begin_frame = 1'b0;
      checks++; if (update_done !== 1'b1) begin failures++; $display("FAIL b2b_commit_done got=%b exp=1", update_done); end
      checks++; if (dropped_frames !== 16'd2 || frame_count !== 16'd2) begin failures++; $display("FAIL b2b_commit got drop=%0d frames=%0d exp 2 2", dropped_frames, frame_count); end
      @(posedge clk_render); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_no_restart got busy=%b exp=0", busy); end
   endtask

   task automatic test_pause();
      logic got;
      apply_reset();
      frame(1'b0, got); model_step();
      checks++; if (!got) begin failures++; $display("FAIL pause_setup got=no update exp=update"); end
      @(posedge clk_render); #1; pause = 1'b1; begin_frame = 1'b1;
      @(posedge clk_render); #1; begin_frame = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++; if (update_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL pause_idle_%0d got done=%b busy=%b exp 0 0", k, update_done, busy); end
         @(posedge clk_render); #1;
      end
      pause = 1'b0;
      checks++; if (offset_x !== 32'(m_offx) || sin_y !== 32'(m_sin)) begin failures++; $display("FAIL pause_hold got x=%h s=%h exp x=%h s=%h", offset_x, sin_y, 32'(m_offx), 32'(m_sin)); end
      checks++; if (frame_count !== 16'(m_frames) || dropped_frames !== 16'd0) begin failures++; $display("FAIL pause_counters got %0d/%0d exp %0d/0", frame_count, dropped_frames, m_frames); end
   endtask

   task automatic test_random();
      logic p;
      int   extra;
      apply_reset();
      for (int it = 0; it < 60; it++) begin
         p     = ($urandom_range(0, 3) == 0);
         extra = p ? 0 : int'($urandom_range(0, 3));
         @(posedge clk_render); #1; pause = p; begin_frame = 1'b1;
         @(posedge clk_render); #1; begin_frame = 1'b0; pause = 1'($urandom_range(0, 1));
         for (int k = 1; k <= 3; k++) begin
            if (k == extra) begin_frame = 1'b1;
            @(posedge clk_render); #1; begin_frame = 1'b0;
            if (p) begin
               checks++; if (update_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rand_paused_%0d got done=%b busy=%b exp 0 0", it, update_done, busy); end
            end
         end
         pause = 1'b0;
         if (!p) begin
            model_step();
            if (extra != 0) m_drops++;
            checks++; if (update_done !== 1'b1) begin failures++; $display("FAIL rand_done_%0d got=%b exp=1", it, update_done); end
         end
         checks++; if (offset_x !== 32'(m_offx) || offset_y !== 32'(m_offy)) begin failures++; $display("FAIL rand_offsets_%0d got %h/%h exp %h/%h", it, offset_x, offset_y, 32'(m_offx), 32'(m_offy)); end
         checks++; if (sin_y !== 32'(m_sin) || cos_y !== 32'(m_cos)) begin failures++; $display("FAIL rand_rot_%0d got %h/%h exp %h/%h", it, sin_y, cos_y, 32'(m_sin), 32'(m_cos)); end
         checks++; if (frame_count !== 16'(m_frames) || dropped_frames !== 16'(m_drops)) begin failures++; $display("FAIL rand_counts_%0d got %0d/%0d exp %0d/%0d", it, frame_count, dropped_frames, m_frames, m_drops); end
         repeat ($urandom_range(0, 2)) @(posedge clk_render);
      end
   endtask

   task automatic test_wrap_rotation();
      logic got;
      apply_reset();
      for (int n = 1; n <= 515; n++) begin
         frame(1'b0, got); model_step();
         checks++; if (!got) begin failures++; $display("FAIL wrap_timeout_%0d got=no update exp=update", n); end
         checks++; if (offset_x !== 32'(m_offx) || offset_y !== 32'(m_offy)) begin failures++; $display("FAIL wrap_offsets_%0d got %h/%h exp %h/%h", n, offset_x, offset_y, 32'(m_offx), 32'(m_offy)); end
         checks++; if (sin_y !== 32'(m_sin) || cos_y !== 32'(m_cos) || frame_count !== 16'(n)) begin failures++; $display("FAIL wrap_rot_%0d got %h/%h/%0d exp %h/%h/%0d", n, sin_y, cos_y, frame_count, 32'(m_sin), 32'(m_cos), n); end
         if (n == 320) begin checks++; if (offset_x !== 32'h0050_0000) begin failures++; $display("FAIL x_at_320 got=%h exp=00500000", offset_x); end end
         if (n == 321) begin checks++; if (offset_x !== 32'hFFB0_0000) begin failures++; $display("FAIL x_at_321 got=%h exp=FFB00000", offset_x); end end
         if (n == 480) begin checks++; if (offset_y !== 32'h003C_0000) begin failures++; $display("FAIL y_at_480 got=%h exp=003C0000", offset_y); end end
         if (n == 481) begin checks++; if (offset_y !== 32'h0) begin failures++; $display("FAIL y_at_481 got=%h exp=0", offset_y); end end
         if (n == 128) begin checks++; if (sin_y < 32'h0000_FF00 || sin_y > 32'h0001_0100) begin failures++; $display("FAIL sin_at_128 got=%h exp=00010000+-100", sin_y); end end
         if (n == 512) begin checks++; if (sin_y !== 32'h0 || cos_y !== 32'h0001_0000) begin failures++; $display("FAIL rot_at_512 got %h/%h exp 0/00010000", sin_y, cos_y); end end
         if (n == 513) begin checks++; if (sin_y !== 32'h0000_0324 || cos_y !== 32'h0000_FFF7) begin failures++; $display("FAIL rot_at_513 got %h/%h exp 00000324/0000FFF7", sin_y, cos_y); end end
      end
   endtask

   task automatic test_reset_mid();
      logic got;
      apply_reset();
      frame(1'b0, got);
      checks++; if (!got) begin failures++; $display("FAIL midrst_setup got=no update exp=update"); end
      @(posedge clk_render); #1; begin_frame = 1'b1;
      @(posedge clk_render); #1; begin_frame = 1'b0;
      @(posedge clk_render); #1;
      #2 btn_rst_n = 1'b0;
      #1;
      checks++; if (offset_x !== 32'hFFB0_0000 || offset_y !== 32'h0) begin failures++; $display("FAIL midrst_offsets got %h/%h exp FFB00000/0", offset_x, offset_y); end
      checks++; if (sin_y !== 32'h0 || cos_y !== 32'h0001_0000) begin failures++; $display("FAIL midrst_rot got %h/%h exp 0/00010000", sin_y, cos_y); end
      checks++; if (frame_count !== 16'd0 || dropped_frames !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got f=%0d d=%0d busy=%b exp 0 0 0", frame_count, dropped_frames, busy); end
      @(posedge clk_render); #1;
      checks++; if (busy !== 1'b0 || update_done !== 1'b0) begin failures++; $display("FAIL midrst_next got busy=%b done=%b exp 0 0", busy, update_done); end
      btn_rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_pause();
      test_random();
      test_wrap_rotation();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
